// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for two requesters (ALU, load unit) with a registered RegFile write port and a pending-write scoreboard.
// Define REGFILE_WB_RR_ARB_EN for round-robin arbitration; otherwise the load unit (req1) always wins contention.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reserve_valid,
    input  logic [4:0]            reserve_addr,
    output logic                  reserve_ready,
    input  logic                  req0_valid,
    input  logic [4:0]            req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [4:0]            req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_we,
    output logic [4:0]            rf_wa,
    output logic [DATA_WIDTH-1:0] rf_wd,
    input  logic [4:0]            chk_ra1,
    input  logic [4:0]            chk_ra2,
    output logic                  hazard,
    output logic [31:0]           pending
);

    logic [31:0]           pending_q, pending_d;
    logic                  rf_we_q, rf_we_d;
    logic [4:0]            rf_wa_q, rf_wa_d;
    logic [DATA_WIDTH-1:0] rf_wd_q, rf_wd_d;
    logic                  grant0, grant1;
    logic [4:0]            acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  clear_hit;

`ifdef REGFILE_WB_RR_ARB_EN
    // last1_q = 1 when req1 was granted most recently; reset value hands the first contention to req0
    logic last1_q, last1_d;

    always_comb begin
        grant0  = req0_valid && (!req1_valid || last1_q);
        grant1  = req1_valid && (!req0_valid || !last1_q);
        last1_d = last1_q;
        if (grant0) begin
            last1_d = 1'b0;
        end else if (grant1) begin
            last1_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end
`else
    always_comb begin
        grant1 = req1_valid;
        grant0 = req0_valid && !req1_valid;
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        acc_addr = grant1 ? req1_addr : req0_addr;
        acc_data = grant1 ? req1_data : req0_data;
    end

    // A register being committed this cycle cannot be re-reserved until its bit is visibly clear
    assign clear_hit     = rf_we_q && (rf_wa_q == reserve_addr);
    assign reserve_ready = reserve_valid &&
                           ((reserve_addr == 5'd0) || (!pending_q[reserve_addr] && !clear_hit));

    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if ((grant0 || grant1) && (acc_addr != 5'd0)) begin
            rf_we_d = 1'b1;
            rf_wa_d = acc_addr;
            rf_wd_d = acc_data;
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (rf_we_q) begin
            pending_d[rf_wa_q] = 1'b0;
        end
        if (reserve_ready && (reserve_addr != 5'd0)) begin
            pending_d[reserve_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
        end else begin
            pending_q <= pending_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
        end
    end

    assign hazard  = pending_q[chk_ra1] | pending_q[chk_ra2];
    assign pending = pending_q;
    assign rf_we   = rf_we_q;
    assign rf_wa   = rf_wa_q;
    assign rf_wd   = rf_wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-cycle vector table plus hand sequences for arbitration and reset.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        reserve_valid;
    logic [4:0]  reserve_addr;
    logic        reserve_ready;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  chk_ra1, chk_ra2;
    logic        hazard;
    logic [31:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr), .reserve_ready(reserve_ready),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .hazard(hazard), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rv, ra, v0, a0, d0, v1, a1, d1, c1, c2;
        logic [31:0] e_rr, e_r0, e_r1, e_we, e_wa, e_wd, e_hz, e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [31:0] rv, ra, v0, a0, d0, v1, a1, d1, c1, c2,
        input logic [31:0] e_rr, e_r0, e_r1, e_we, e_wa, e_wd, e_hz, e_pend);
        vec_t t;
        t.rv = rv; t.ra = ra; t.v0 = v0; t.a0 = a0; t.d0 = d0;
        t.v1 = v1; t.a1 = a1; t.d1 = d1; t.c1 = c1; t.c2 = c2;
        t.e_rr = e_rr; t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_we = e_we;
        t.e_wa = e_wa; t.e_wd = e_wd; t.e_hz = e_hz; t.e_pend = e_pend;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle();
        reserve_valid = 1'b0; reserve_addr = '0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        chk_ra1 = '0; chk_ra2 = '0;
    endtask

    task automatic apply(input vec_t t);
        reserve_valid = t.rv[0]; reserve_addr = t.ra[4:0];
        req0_valid = t.v0[0]; req0_addr = t.a0[4:0]; req0_data = t.d0;
        req1_valid = t.v1[0]; req1_addr = t.a1[4:0]; req1_data = t.d1;
        chk_ra1 = t.c1[4:0]; chk_ra2 = t.c2[4:0];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int exp_g[4];
    int prev_addr;

    initial begin
`ifdef REGFILE_WB_RR_ARB_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        //              rv ra v0 a0 d0       v1 a1 d1    c1 c2 | rr r0 r1 we wa d         hz pend
        vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,    0, 0,  0, 0, 0, 0, 0, 0,      0, 32'h00));
        vecs.push_back(mk(1, 5, 0, 0, 0,      0, 0, 0,    0, 0,  1, 0, 0, 0, 0, 0,      0, 32'h00));
        vecs.push_back(mk(0, 0, 1, 5, 'hDEAD, 0, 0, 0,    5, 0,  0, 1, 0, 0, 0, 0,      1, 32'h20));
        vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,    5, 0,  0, 0, 0, 1, 5, 'hDEAD, 1, 32'h20));
        vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,    5, 0,  0, 0, 0, 0, 5, 'hDEAD, 0, 32'h00));
        vecs.push_back(mk(0, 0, 1, 0, 'h1234, 0, 0, 0,    0, 0,  0, 1, 0, 0, 5, 'hDEAD, 0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,    0, 0,  0, 0, 0, 0, 5, 'hDEAD, 0, 32'h00));
        vecs.push_back(mk(1, 7, 0, 0, 0,      0, 0, 0,    0, 0,  1, 0, 0, 0, 5, 'hDEAD, 0, 32'h00));
        vecs.push_back(mk(1, 7, 0, 0, 0,      0, 0, 0,    7, 0,  0, 0, 0, 0, 5, 'hDEAD, 1, 32'h80));
        vecs.push_back(mk(1, 0, 0, 0, 0,      0, 0, 0,    0, 0,  1, 0, 0, 0, 5, 'hDEAD, 0, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,    0, 7,  0, 0, 0, 0, 5, 'hDEAD, 1, 32'h80));
        vecs.push_back(mk(1, 3, 0, 0, 0,      0, 0, 0,    0, 0,  1, 0, 0, 0, 5, 'hDEAD, 0, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0,      1, 3, 'h33, 0, 0,  0, 0, 1, 0, 5, 'hDEAD, 0, 32'h88));
        vecs.push_back(mk(1, 3, 0, 0, 0,      0, 0, 0,    0, 0,  0, 0, 0, 1, 3, 'h33,   0, 32'h88));
        vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,    3, 0,  0, 0, 0, 0, 3, 'h33,   0, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0,      1, 10, 'hA, 0, 0,  0, 0, 1, 0, 3, 'h33,   0, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,    0, 0,  0, 0, 0, 1, 10, 'hA,   0, 32'h80));
        vecs.push_back(mk(0, 0, 1, 7, 'h77,   0, 0, 0,    0, 0,  0, 1, 0, 0, 10, 'hA,   0, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0,      1, 4, 'h44, 0, 0,  0, 0, 1, 1, 7, 'h77,   0, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,    0, 0,  0, 0, 0, 1, 4, 'h44,   0, 32'h00));
        vecs.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,    0, 0,  0, 0, 0, 0, 4, 'h44,   0, 32'h00));

        // Reset values and ready behaviour while reset is held, before any clock edge
        rst = 1'b1;
        idle();
        #2;
        chk("reset_state", 128'({rf_we, rf_wa, rf_wd, pending}), 128'(0));
        req0_valid = 1'b1; reserve_valid = 1'b1; reserve_addr = 5'd4;
        #1;
        chk("ready_in_reset", 128'({req0_ready, req1_ready, reserve_ready}), 128'(3'b101));
        next_cycle();
        chk("reset_hold_over_edge", 128'({rf_we, pending}), 128'(0));
        idle();
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #4;
            chk($sformatf("vec%0d", i),
                128'({reserve_ready, req0_ready, req1_ready, rf_we, rf_wa, rf_wd, hazard, pending}),
                128'({vecs[i].e_rr[0], vecs[i].e_r0[0], vecs[i].e_r1[0], vecs[i].e_we[0],
                      vecs[i].e_wa[4:0], vecs[i].e_wd, vecs[i].e_hz[0], vecs[i].e_pend}));
            next_cycle();
        end

        // Continuous contention from reset: both requesters hold their request every cycle
        rst = 1'b1; #1; rst = 1'b0;
        idle();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA0;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB0;
        prev_addr = 0;
        for (int i = 0; i < 4; i++) begin
            #4;
            chk($sformatf("contend_grant%0d", i), 128'({req0_ready, req1_ready}),
                128'((exp_g[i] == 1) ? 2'b01 : 2'b10));
            if (i > 0) begin
                chk($sformatf("contend_write%0d", i), 128'({rf_we, rf_wa}), 128'({1'b1, 5'(prev_addr)}));
            end
            prev_addr = (exp_g[i] == 1) ? 2 : 1;
            next_cycle();
        end
        idle();
        #4;
        chk("contend_last_write", 128'({rf_we, rf_wa, pending}), 128'({1'b1, 5'(prev_addr), 32'h0}));
        next_cycle();

        // Reset asserted in the cycle after accepting a write to x9
        rst = 1'b1; #1; rst = 1'b0;
        reserve_valid = 1'b1; reserve_addr = 5'd9;
        next_cycle();
        idle();
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        #4;
        chk("x9_accept", 128'({req0_ready, pending}), 128'({1'b1, 32'h200}));
        next_cycle();
        idle();
        rst = 1'b1;
        #1;
        chk("x9_reset_clears", 128'({rf_we, rf_wa, rf_wd, pending}), 128'(0));
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk($sformatf("x9_no_pulse%0d", i), 128'({rf_we, rf_wa, rf_wd, pending}), 128'(0));
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
